banyan_readout: RTL and testbench
=================================

# banyan_readout

Readout engine for the banyan capture memory. Once a capture has stopped, it walks the memory's read-only port in chronological order, oldest sample first, following the circular buffer across wrap-around. It streams the words out on a valid/ready interface with full backpressure. It sits between the banyan_mem read port (`ro_addr`/`ro_data`, same clock) and a downstream consumer such as a local-bus FIFO or a packetizer.

## Interface
Parameters:
- `aw`, 12, address width of one memory block; total read address width is aw+3.
- `dw`, 16, data width.

Ports:
- `clk`  in  1  single clock for everything, including the memory read port.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a readout.
- `abort`  in  1  one-cycle request to cancel a readout in progress.
- `run`  in  1  capture-running flag from banyan_mem.
- `full`  in  1  buffer-has-wrapped flag from banyan_mem.
- `pointer`  in  aw+3  next write address from banyan_mem.
- `ro_addr`  out  aw+3  memory read address, registered.
- `ro_data`  in  dw  memory read data, valid one cycle after `ro_addr`.
- `out_data`  out  dw  stream data.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_last`  out  1  marks the final word of the readout.
- `busy`  out  1  high whenever the block is not IDLE.
- `done`  out  1  one-cycle pulse when a readout completes or is aborted.
- `err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- States:
  - IDLE: waiting for `start`.
  - READ: issuing memory reads.
  - DRAIN: all reads issued; emptying the FIFO.
- Start acceptance: `start` is accepted only in IDLE with `run`=0.
  - `start` in IDLE while `run`=1 pulses `err` and the block stays in IDLE.
  - `start` while `busy`=1 is ignored: no `err`, no effect.
- On acceptance, snapshot `pointer` and `full`:
  - full=1: length N = 2^(aw+3), first address = `pointer`.
  - full=0: length N = `pointer`, first address = 0.
  - N=0 (full=0, pointer=0): go straight to IDLE, pulse `done`, emit no beats.
- Word counter is aw+4 bits wide, so that N = 2^(aw+3) is representable.
- Read address increments modulo 2^(aw+3). Going from 2^(aw+3)−1 to 0 is normal operation, not an error.
- Data FIFO:
  - 4 entries deep, holding `ro_data` captured one cycle after each issued read.
  - An in-flight flag tracks the single outstanding read.
  - A read is issued in a cycle only if FIFO count + in-flight ≤ 2. This guarantees no overflow under any `out_ready` pattern.
- Transitions:
  - READ → DRAIN when the N-th read is issued.
  - DRAIN → IDLE when the last word is accepted (`out_valid`&`out_ready`&`out_last`). `done` pulses in that same transition.
- `out_last` is high only on the N-th beat.
- Abort in READ or DRAIN: flush the FIFO, clear the in-flight flag, drop `out_valid` on the next cycle, go to IDLE, pulse `done`. An abort in the same cycle as the final handshake still completes normally, with a single `done`.
- Inputs `pointer`, `full` and `run` are ignored after the snapshot.

## Timing
- Reset values:
  - `ro_addr`=0.
  - `out_valid`, `out_last`, `busy`, `done`, `err` = 0.
  - `out_data`=0.
  - State = IDLE; FIFO empty.
- `start` sampled at edge k:
  - `busy`=1 and `ro_addr` = first address after edge k.
  - `ro_data` is valid during cycle k+1.
  - It is captured at edge k+2.
  - `out_valid`=1 from edge k+2.
- With `out_ready` held high: one beat per cycle, no bubbles. N beats occupy cycles k+2 .. k+N+1.
- Backpressure: when `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` stay stable. Beats are never dropped or duplicated.
- `done` is asserted in the cycle after the final handshake edge. `busy` falls in that same cycle.
- `err` is asserted the cycle after the rejected `start`.

## Test plan
- aw=4 (N=128); full=1, pointer=37, `out_ready` always 1 → beats read addresses 37..127, 0..36 in order; 128 beats; `out_last` on the beat from address 36; `done` one cycle later.
- full=0, pointer=5 → beats from addresses 0..4; `out_last` on the 5th beat. Separately, full=0, pointer=0 → zero beats, `done` pulse only.
- Random `out_ready` (30 % high), full=1 → the 128-beat sequence matches the memory model exactly; `out_data` is stable while stalled; FIFO count never exceeds 4.
- `start` with run=1 → `err` pulse, `busy` stays 0, `ro_addr` unchanged. A second `start` during READ → ignored.
- `abort` after 10 beats → `out_valid` drops on the next cycle, `done` pulses once, IDLE; a new `start` then restarts from a fresh snapshot.
- `reset_n` asserted mid-READ, asynchronously between edges → all outputs immediately take their reset values; after release, the block is IDLE and the next `start` works.

Source files
------------

// File: rtl/banyan_readout.sv
// Purpose : chronological readout of the banyan capture buffer (oldest sample first) onto a
//           valid/ready stream; ports: start/abort/run/full/pointer control, ro_addr/ro_data
//           memory read port, out_* stream, busy/done/err status.
// Latency : start at edge k -> ro_addr valid after k, first beat valid from edge k+2, then 1 beat/cycle.
// Backpr. : out_ready low holds out_data/out_last; reads pause once FIFO + in-flight reach 3.
module banyan_readout #(
    parameter int aw = 12,
    parameter int dw = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic            run,
    input  logic            full,
    input  logic [aw+2:0]   pointer,
    output logic [aw+2:0]   ro_addr,
    input  logic [dw-1:0]   ro_data,
    output logic [dw-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int AW3 = aw + 3;
    localparam int CW  = aw + 4;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW3-1:0]  addr_q, addr_d;
    logic [CW-1:0]   reads_left_q, reads_left_d;
    logic [CW-1:0]   beats_left_q, beats_left_d;
    logic            inflight_q, inflight_d;
    logic [2:0]      count_q, count_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [dw-1:0]   fifo_q [4];

    logic            start_ok, start_rej, abort_act;
    logic [CW-1:0]   snap_len;
    logic [AW3-1:0]  snap_first;
    logic [2:0]      occ;
    logic            issue, push, pop, last_hs, fifo_vld;

    assign start_ok   = (state_q == S_IDLE) && start && !run;
    assign start_rej  = (state_q == S_IDLE) && start && run;
    assign abort_act  = abort && (state_q != S_IDLE);
    // A wrapped buffer holds the full 2^(aw+3) words, oldest at the write pointer.
    assign snap_len   = full ? (CW'(1) << AW3) : {1'b0, pointer};
    assign snap_first = full ? pointer : '0;
    assign occ        = count_q + {2'b00, inflight_q};
    // Keeping FIFO + in-flight at most 2 before a new read bounds occupancy at 3 whatever out_ready does.
    assign issue      = (state_q == S_READ) && !abort && (occ <= 3'd2);
    assign fifo_vld   = (count_q != 3'd0);
    assign push       = inflight_q;
    assign pop        = fifo_vld && out_ready;
    assign last_hs    = pop && (beats_left_q == CW'(1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok && (snap_len != '0)) state_d = S_READ;
            S_READ: begin
                if (abort)                                    state_d = S_IDLE;
                else if (issue && (reads_left_q == CW'(1)))   state_d = S_DRAIN;
            end
            S_DRAIN: if (abort || last_hs) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        out_valid = fifo_vld;
        out_data  = fifo_vld ? fifo_q[rd_ptr_q] : '0;
        out_last  = fifo_vld && (beats_left_q == CW'(1));
        ro_addr   = addr_q;
        done      = done_q;
        err       = err_q;
    end

    // Datapath next-state
    always_comb begin
        addr_d       = addr_q;
        reads_left_d = reads_left_q;
        beats_left_d = beats_left_q;
        inflight_d   = issue;
        count_d      = count_q + {2'b00, push} - {2'b00, pop};
        wr_ptr_d     = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
        err_d        = start_rej;
        // Final handshake and abort in the same cycle both end here, so one done pulse.
        done_d       = (state_q != S_IDLE) && (abort || last_hs);

        if (pop) beats_left_d = beats_left_q - CW'(1);

        if (issue) begin
            addr_d       = addr_q + AW3'(1);
            reads_left_d = reads_left_q - CW'(1);
        end

        if (start_ok) begin
            addr_d       = snap_first;
            reads_left_d = snap_len;
            beats_left_d = snap_len;
            done_d       = (snap_len == '0);
        end

        if (abort_act) begin
            inflight_d   = 1'b0;
            count_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            reads_left_d = '0;
            beats_left_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            reads_left_q <= '0;
            beats_left_q <= '0;
            inflight_q   <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            reads_left_q <= reads_left_d;
            beats_left_q <= beats_left_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !abort_act) fifo_q[wr_ptr_q] <= ro_data;
    end

endmodule

// File: tb/tb_banyan_readout.sv
module tb_banyan_readout;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << (AW + 3);

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            run = 1'b0;
    logic            full = 1'b0;
    logic [AW+2:0]   pointer = '0;
    logic [AW+2:0]   ro_addr;
    logic [DW-1:0]   ro_data;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            out_last;
    logic            busy;
    logic            done;
    logic            err;

    int passes = 0;
    int total  = 0;

    logic [DW-1:0] mem [DEPTH];

    banyan_readout #(.aw(AW), .dw(DW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .run(run),
        .full(full), .pointer(pointer), .ro_addr(ro_addr), .ro_data(ro_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous-read capture memory: data for the address sampled at an edge is visible after it.
    always @(posedge clk) ro_data <= mem[ro_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ro_addr"}, 32'(ro_addr), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_last"}, 32'(out_last), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    // One readout. Expected beats come straight from the buffer definition: oldest word first,
    // N words, addresses taken modulo the buffer size.
    task automatic readout(input bit f, input int ptr, input int ready_pct,
                           input int abort_after, input bit dbl_start, input string tag);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] exp_word;
        logic [DW-1:0] prev_d;
        bit            prev_l, prev_stall, finished;
        int            n, first, c, beats;

        n     = f ? DEPTH : ptr;
        first = f ? ptr : 0;
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(first + i) % DEPTH]);

        full = f; pointer = (AW+3)'(ptr); run = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Snapshot inputs must be irrelevant from here on.
        full = ~f; pointer = (AW+3)'($urandom_range(0, DEPTH - 1));

        if (n == 0) begin
            chk({tag, "_empty_done"}, 32'(done), 1);
            chk({tag, "_empty_busy"}, 32'(busy), 0);
            chk({tag, "_empty_valid"}, 32'(out_valid), 0);
            @(negedge clk);
            chk({tag, "_empty_done_clr"}, 32'(done), 0);
            return;
        end

        chk({tag, "_busy_start"}, 32'(busy), 1);
        chk({tag, "_first_addr"}, 32'(ro_addr), 32'(first));

        c = 0; beats = 0; prev_stall = 0; finished = 0; prev_d = '0; prev_l = 0;
        while (!finished && c < 5000) begin
            if (prev_stall) begin
                chk({tag, "_stall_data"}, 32'(out_data), 32'(prev_d));
                chk({tag, "_stall_last"}, 32'(out_last), 32'(prev_l));
            end
            if (dbl_start) begin
                start = (c == 3);
                run   = (c == 3);
                if (c == 4) chk({tag, "_dbl_start_no_err"}, 32'(err), 0);
            end
            chk({tag, "_fifo_bound"}, 32'(dut.count_q <= 3'd4), 1);
            if (abort_after > 0 && beats == abort_after) begin
                abort = 1'b1; out_ready = 1'b0;
                @(negedge clk);
                abort = 1'b0;
                chk({tag, "_abort_valid"}, 32'(out_valid), 0);
                chk({tag, "_abort_done"}, 32'(done), 1);
                chk({tag, "_abort_busy"}, 32'(busy), 0);
                @(negedge clk);
                chk({tag, "_abort_done_once"}, 32'(done), 0);
                finished = 1;
            end else begin
                out_ready = ($urandom_range(0, 99) < ready_pct);
                if (out_valid && out_ready) begin
                    exp_word = exp_q.pop_front();
                    chk({tag, "_data"}, 32'(out_data), 32'(exp_word));
                    chk({tag, "_last"}, 32'(out_last), 32'(exp_q.size() == 0));
                    if (ready_pct >= 100) chk({tag, "_beat_cycle"}, c, beats + 2);
                    beats++;
                    if (exp_q.size() == 0) begin
                        @(negedge clk);
                        chk({tag, "_done"}, 32'(done), 1);
                        chk({tag, "_busy_end"}, 32'(busy), 0);
                        chk({tag, "_valid_end"}, 32'(out_valid), 0);
                        @(negedge clk);
                        chk({tag, "_done_clr"}, 32'(done), 0);
                        finished = 1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_d     = out_data;
                prev_l     = out_last;
                if (!finished) begin
                    @(negedge clk);
                    c++;
                end
            end
        end
        start = 1'b0; run = 1'b0;
        if (!finished) chk({tag, "_timeout"}, 0, 1);
        else if (abort_after == 0) chk({tag, "_beat_count"}, beats, n);
    endtask

    logic [AW+2:0] addr_before;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);

        // Reset state
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        // Wrapped buffer, continuous ready: 37..127 then 0..36
        readout(1'b1, 37, 100, 0, 1'b0, "wrap37");
        // Partial buffer of 5 words
        readout(1'b0, 5, 100, 0, 1'b0, "part5");
        // Empty buffer
        readout(1'b0, 0, 100, 0, 1'b0, "empty");
        // Heavy backpressure
        readout(1'b1, 90, 30, 0, 1'b0, "bp30");

        // Start while capture is running is rejected
        addr_before = ro_addr;
        run = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej_err", 32'(err), 1);
        chk("rej_busy", 32'(busy), 0);
        chk("rej_addr", 32'(ro_addr), 32'(addr_before));
        @(negedge clk);
        chk("rej_err_clr", 32'(err), 0);
        run = 1'b0;

        // Second start during READ is ignored
        readout(1'b1, 3, 100, 0, 1'b1, "dbl");

        // Abort after 10 beats, then a fresh readout
        readout(1'b1, 60, 100, 10, 1'b0, "abort");
        readout(1'b0, 17, 50, 0, 1'b0, "after_abort");

        // Asynchronous reset in the middle of READ
        full = 1'b1; pointer = 7'd100; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("async_reset_idle", 32'(busy), 0);
        readout(1'b0, 5, 100, 0, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
